// File: rtl/gpu_cv_pkg.sv
// Shared definitions for the VRAM->VRAM copy path: step codes, VRAM geometry and
// the command-size decoders used by the coordinate walker and the copy state machine.
package gpu_cv_pkg;

   localparam logic [2:0] X_ASIS      = 3'd0;
   localparam logic [2:0] X_TRI_NEXT  = 3'd1;
   localparam logic [2:0] X_CV_START  = 3'd6;

   localparam logic [2:0] Y_ASIS      = 3'd0;
   localparam logic [2:0] Y_TRI_NEXT  = 3'd4;
   localparam logic [2:0] Y_CV_ZERO   = 3'd6;

   localparam int WORDS_PER_LINE = 512;
   localparam int LINES          = 512;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } cv_state_e;

   // A zero size field encodes the full VRAM extent.
   function automatic logic [10:0] cv_width(input logic [9:0] w);
      return (w == 10'd0) ? 11'(2 * WORDS_PER_LINE) : {1'b0, w};
   endfunction

   function automatic logic [9:0] cv_height(input logic [8:0] h);
      return (h == 9'd0) ? 10'(LINES) : {1'b0, h};
   endfunction

endpackage

// File: rtl/cv_wrap_add9.sv
// 9-bit base + offset with modulo-512 wrap, matching VRAM wrap-around at the
// right and bottom edges.
module cv_wrap_add9 (
   input  logic [8:0] base_i,
   input  logic [8:0] off_i,
   output logic [8:0] sum_o
);

   assign sum_o = base_i + off_i;

endmodule

// File: rtl/cv_copy_coord.sv
// Coordinate walker for the VRAM copy: latches one command, steps pair index and
// line on the state machine's step codes, and forms flags and word addresses.
module cv_copy_coord
   import gpu_cv_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        i_start,
   input  logic [9:0]  i_srcX,
   input  logic [8:0]  i_srcY,
   input  logic [9:0]  i_dstX,
   input  logic [8:0]  i_dstY,
   input  logic [9:0]  i_width,
   input  logic [8:0]  i_height,
   input  logic [2:0]  i_nextX,
   input  logic [2:0]  i_nextY,
   input  logic        i_done,
   output logic        o_active,
   output logic        o_isWidthNot1,
   output logic        o_xb_0,
   output logic        o_wb_0,
   output logic        o_currPairIsLineLast,
   output logic        o_nextPairIsLineLast,
   output logic        o_endVertical,
   output logic [17:0] o_srcAddr,
   output logic [17:0] o_dstAddr,
   output logic        o_err
);

   cv_state_e   state_q, state_d;
   logic [9:0]  srcx_q, srcx_d;
   logic [8:0]  srcy_q, srcy_d;
   logic [9:0]  dstx_q, dstx_d;
   logic [8:0]  dsty_q, dsty_d;
   logic [10:0] width_q, width_d;
   logic [9:0]  height_q, height_d;
   logic [9:0]  idx_q, idx_d;
   logic [9:0]  line_q, line_d;
   logic        err_q, err_d;

   // NOTE: synchronous reset clears every register; no storage here is left unreset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         srcx_q   <= '0;
         srcy_q   <= '0;
         dstx_q   <= '0;
         dsty_q   <= '0;
         width_q  <= '0;
         height_q <= '0;
         idx_q    <= '0;
         line_q   <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         srcx_q   <= srcx_d;
         srcy_q   <= srcy_d;
         dstx_q   <= dstx_d;
         dsty_q   <= dsty_d;
         width_q  <= width_d;
         height_q <= height_d;
         idx_q    <= idx_d;
         line_q   <= line_d;
         err_q    <= err_d;
      end
   end

   always_comb begin
      // NOTE: every next-state value defaults to its register first so no path infers a latch.
      state_d  = state_q;
      srcx_d   = srcx_q;
      srcy_d   = srcy_q;
      dstx_d   = dstx_q;
      dsty_d   = dsty_q;
      width_d  = width_q;
      height_d = height_q;
      idx_d    = idx_q;
      line_d   = line_q;
      err_d    = err_q;

      case (state_q)
         ST_IDLE: begin
            if (i_start) begin
               state_d  = ST_RUN;
               srcx_d   = i_srcX;
               srcy_d   = i_srcY;
               dstx_d   = i_dstX;
               dsty_d   = i_dstY;
               width_d  = cv_width(i_width);
               height_d = cv_height(i_height);
               idx_d    = '0;
               line_d   = '0;
               err_d    = 1'b0;
            end
         end
         ST_RUN: begin
            if (i_done) begin
               state_d = ST_IDLE;
            end else begin
               case (i_nextX)
                  X_ASIS:     idx_d = idx_q;
                  X_TRI_NEXT: idx_d = idx_q + 10'd1;
                  X_CV_START: idx_d = '0;
                  default:    err_d = 1'b1;
               endcase
               case (i_nextY)
                  Y_ASIS:     line_d = line_q;
                  Y_TRI_NEXT: line_d = line_q + 10'd1;
                  Y_CV_ZERO:  line_d = '0;
                  default:    err_d  = 1'b1;
               endcase
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Last pair index of a line, counted from the pair holding srcX.
   logic [10:0] span;
   logic [9:0]  last_idx;
   assign span     = {10'd0, srcx_q[0]} + width_q - 11'd1;
   assign last_idx = span[10:1];

   assign o_active             = (state_q == ST_RUN);
   assign o_isWidthNot1        = (width_q != 11'd1);
   assign o_xb_0               = srcx_q[0];
   assign o_wb_0               = width_q[0];
   assign o_currPairIsLineLast = (idx_q == last_idx);
   assign o_nextPairIsLineLast = (({1'b0, idx_q} + 11'd1) == {1'b0, last_idx});
   assign o_endVertical        = (line_q == height_q - 10'd1);
   assign o_err                = err_q;

   logic [8:0] src_x_f, src_y_f, dst_x_f, dst_y_f;

   cv_wrap_add9 u_src_x (.base_i(srcx_q[9:1]), .off_i(idx_q[8:0]),  .sum_o(src_x_f));
   cv_wrap_add9 u_src_y (.base_i(srcy_q),      .off_i(line_q[8:0]), .sum_o(src_y_f));
   cv_wrap_add9 u_dst_x (.base_i(dstx_q[9:1]), .off_i(idx_q[8:0]),  .sum_o(dst_x_f));
   cv_wrap_add9 u_dst_y (.base_i(dsty_q),      .off_i(line_q[8:0]), .sum_o(dst_y_f));

   assign o_srcAddr = {src_y_f, src_x_f};
   assign o_dstAddr = {dst_y_f, dst_x_f};

endmodule

// File: tb/tb_cv_copy_coord.sv
// Directed bench for cv_copy_coord: command load, stepping, line flags, address
// wrap, full-size encoding, done priority, illegal codes and reset.
module tb_cv_copy_coord;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_start;
   logic [9:0]  i_srcX;
   logic [8:0]  i_srcY;
   logic [9:0]  i_dstX;
   logic [8:0]  i_dstY;
   logic [9:0]  i_width;
   logic [8:0]  i_height;
   logic [2:0]  i_nextX;
   logic [2:0]  i_nextY;
   logic        i_done;
   logic        o_active;
   logic        o_isWidthNot1;
   logic        o_xb_0;
   logic        o_wb_0;
   logic        o_currPairIsLineLast;
   logic        o_nextPairIsLineLast;
   logic        o_endVertical;
   logic [17:0] o_srcAddr;
   logic [17:0] o_dstAddr;
   logic        o_err;

   int checks = 0;
   int errors = 0;

   cv_copy_coord dut (
      .clk(clk), .rst(rst), .i_start(i_start),
      .i_srcX(i_srcX), .i_srcY(i_srcY), .i_dstX(i_dstX), .i_dstY(i_dstY),
      .i_width(i_width), .i_height(i_height),
      .i_nextX(i_nextX), .i_nextY(i_nextY), .i_done(i_done),
      .o_active(o_active), .o_isWidthNot1(o_isWidthNot1),
      .o_xb_0(o_xb_0), .o_wb_0(o_wb_0),
      .o_currPairIsLineLast(o_currPairIsLineLast),
      .o_nextPairIsLineLast(o_nextPairIsLineLast),
      .o_endVertical(o_endVertical),
      .o_srcAddr(o_srcAddr), .o_dstAddr(o_dstAddr), .o_err(o_err)
   );

   always #5 clk = ~clk;

   // Inputs change and outputs are sampled 1 time unit after each rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_cmd(input logic [9:0] sx, input logic [8:0] sy,
                           input logic [9:0] dx, input logic [8:0] dy,
                           input logic [9:0] w,  input logic [8:0] h);
      i_srcX = sx; i_srcY = sy; i_dstX = dx; i_dstY = dy;
      i_width = w; i_height = h;
      i_nextX = 3'd0; i_nextY = 3'd0; i_done = 1'b0;
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
   endtask

   task automatic finish_cmd();
      i_nextX = 3'd0; i_nextY = 3'd0; i_done = 1'b1;
      tick();
      i_done = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; i_start = 1'b1; i_done = 1'b0;
      i_srcX = 10'd5; i_srcY = 9'd7; i_dstX = 10'd9; i_dstY = 9'd3;
      i_width = 10'd3; i_height = 9'd3; i_nextX = 3'd1; i_nextY = 3'd4;
      tick(); tick();
      i_start = 1'b0;
      checks++; if (o_active !== 1'b0) begin errors++; $display("FAIL reset_active got %0b exp 0", o_active); end
      checks++; if (o_srcAddr !== 18'd0) begin errors++; $display("FAIL reset_src got %0h exp 0", o_srcAddr); end
      checks++; if (o_dstAddr !== 18'd0) begin errors++; $display("FAIL reset_dst got %0h exp 0", o_dstAddr); end
      checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL reset_err got %0b exp 0", o_err); end
      checks++; if (o_xb_0 !== 1'b0) begin errors++; $display("FAIL reset_xb0 got %0b exp 0", o_xb_0); end
      checks++; if (o_wb_0 !== 1'b0) begin errors++; $display("FAIL reset_wb0 got %0b exp 0", o_wb_0); end
      rst = 1'b0;
      tick();
   endtask

   // srcX=4 W=4 H=2: lastIdx=(0+3)>>1=1, lastLine=1.
   task automatic test_basic();
      load_cmd(10'd4, 9'd10, 10'd100, 9'd20, 10'd4, 9'd2);
      checks++; if (o_active !== 1'b1) begin errors++; $display("FAIL basic_active got %0b exp 1", o_active); end
      checks++; if (o_srcAddr !== {9'd10, 9'd2}) begin errors++; $display("FAIL basic_src0 got %0h exp %0h", o_srcAddr, {9'd10, 9'd2}); end
      checks++; if (o_dstAddr !== {9'd20, 9'd50}) begin errors++; $display("FAIL basic_dst0 got %0h exp %0h", o_dstAddr, {9'd20, 9'd50}); end
      checks++; if (o_currPairIsLineLast !== 1'b0) begin errors++; $display("FAIL basic_curr0 got %0b exp 0", o_currPairIsLineLast); end
      checks++; if (o_nextPairIsLineLast !== 1'b1) begin errors++; $display("FAIL basic_next0 got %0b exp 1", o_nextPairIsLineLast); end
      checks++; if (o_endVertical !== 1'b0) begin errors++; $display("FAIL basic_endv0 got %0b exp 0", o_endVertical); end
      checks++; if (o_isWidthNot1 !== 1'b1) begin errors++; $display("FAIL basic_wnot1 got %0b exp 1", o_isWidthNot1); end
      i_nextX = 3'd1;
      tick();
      checks++; if (o_currPairIsLineLast !== 1'b1) begin errors++; $display("FAIL basic_curr1 got %0b exp 1", o_currPairIsLineLast); end
      checks++; if (o_srcAddr !== {9'd10, 9'd3}) begin errors++; $display("FAIL basic_src1 got %0h exp %0h", o_srcAddr, {9'd10, 9'd3}); end
      i_nextX = 3'd6; i_nextY = 3'd4;
      tick();
      checks++; if (o_srcAddr !== {9'd11, 9'd2}) begin errors++; $display("FAIL basic_crlf_src got %0h exp %0h", o_srcAddr, {9'd11, 9'd2}); end
      checks++; if (o_endVertical !== 1'b1) begin errors++; $display("FAIL basic_endv1 got %0b exp 1", o_endVertical); end
      finish_cmd();
      checks++; if (o_active !== 1'b0) begin errors++; $display("FAIL basic_done got %0b exp 0", o_active); end
   endtask

   // srcX=3 W=6: lastIdx=(1+5)>>1=3, xb_0=1, wb_0=0.
   task automatic test_odd_start();
      load_cmd(10'd3, 9'd0, 10'd0, 9'd0, 10'd6, 9'd1);
      checks++; if (o_xb_0 !== 1'b1) begin errors++; $display("FAIL odd_xb0 got %0b exp 1", o_xb_0); end
      checks++; if (o_wb_0 !== 1'b0) begin errors++; $display("FAIL odd_wb0 got %0b exp 0", o_wb_0); end
      checks++; if (o_endVertical !== 1'b1) begin errors++; $display("FAIL odd_endv got %0b exp 1", o_endVertical); end
      i_nextX = 3'd1;
      tick(); tick();
      checks++; if (o_nextPairIsLineLast !== 1'b1) begin errors++; $display("FAIL odd_next2 got %0b exp 1", o_nextPairIsLineLast); end
      checks++; if (o_currPairIsLineLast !== 1'b0) begin errors++; $display("FAIL odd_curr2 got %0b exp 0", o_currPairIsLineLast); end
      tick();
      checks++; if (o_currPairIsLineLast !== 1'b1) begin errors++; $display("FAIL odd_curr3 got %0b exp 1", o_currPairIsLineLast); end
      checks++; if (o_nextPairIsLineLast !== 1'b0) begin errors++; $display("FAIL odd_next3 got %0b exp 0", o_nextPairIsLineLast); end
      finish_cmd();
   endtask

   // srcX=1022 -> X field 511; srcY=511 -> both fields wrap to 0.
   task automatic test_wrap();
      load_cmd(10'd1022, 9'd511, 10'd0, 9'd0, 10'd4, 9'd2);
      checks++; if (o_srcAddr !== {9'd511, 9'd511}) begin errors++; $display("FAIL wrap_src0 got %0h exp %0h", o_srcAddr, {9'd511, 9'd511}); end
      i_nextX = 3'd1;
      tick();
      checks++; if (o_srcAddr !== {9'd511, 9'd0}) begin errors++; $display("FAIL wrap_srcx got %0h exp %0h", o_srcAddr, {9'd511, 9'd0}); end
      checks++; if (o_dstAddr !== {9'd0, 9'd1}) begin errors++; $display("FAIL wrap_dstx got %0h exp %0h", o_dstAddr, {9'd0, 9'd1}); end
      i_nextX = 3'd0; i_nextY = 3'd4;
      tick();
      checks++; if (o_srcAddr !== {9'd0, 9'd0}) begin errors++; $display("FAIL wrap_srcy got %0h exp %0h", o_srcAddr, {9'd0, 9'd0}); end
      checks++; if (o_dstAddr !== {9'd1, 9'd1}) begin errors++; $display("FAIL wrap_dsty got %0h exp %0h", o_dstAddr, {9'd1, 9'd1}); end
      finish_cmd();
   endtask

   // Zero size fields: W=1024 -> lastIdx=511, H=512 -> lastLine=511.
   task automatic test_full_size();
      load_cmd(10'd0, 9'd0, 10'd0, 9'd0, 10'd0, 9'd0);
      checks++; if (o_wb_0 !== 1'b0) begin errors++; $display("FAIL full_wb0 got %0b exp 0", o_wb_0); end
      checks++; if (o_isWidthNot1 !== 1'b1) begin errors++; $display("FAIL full_wnot1 got %0b exp 1", o_isWidthNot1); end
      checks++; if (o_endVertical !== 1'b0) begin errors++; $display("FAIL full_endv0 got %0b exp 0", o_endVertical); end
      i_nextX = 3'd1; i_nextY = 3'd4;
      for (int i = 0; i < 510; i++) tick();
      checks++; if (o_nextPairIsLineLast !== 1'b1) begin errors++; $display("FAIL full_next510 got %0b exp 1", o_nextPairIsLineLast); end
      checks++; if (o_currPairIsLineLast !== 1'b0) begin errors++; $display("FAIL full_curr510 got %0b exp 0", o_currPairIsLineLast); end
      checks++; if (o_endVertical !== 1'b0) begin errors++; $display("FAIL full_endv510 got %0b exp 0", o_endVertical); end
      checks++; if (o_srcAddr !== {9'd510, 9'd510}) begin errors++; $display("FAIL full_src510 got %0h exp %0h", o_srcAddr, {9'd510, 9'd510}); end
      tick();
      checks++; if (o_currPairIsLineLast !== 1'b1) begin errors++; $display("FAIL full_curr511 got %0b exp 1", o_currPairIsLineLast); end
      checks++; if (o_endVertical !== 1'b1) begin errors++; $display("FAIL full_endv511 got %0b exp 1", o_endVertical); end
      finish_cmd();
   endtask

   task automatic test_done_priority();
      load_cmd(10'd8, 9'd5, 10'd0, 9'd0, 10'd8, 9'd4);
      i_srcX = 10'd100; i_srcY = 9'd200; i_start = 1'b1;
      tick();
      i_start = 1'b0;
      checks++; if (o_active !== 1'b1) begin errors++; $display("FAIL prio_run_start_active got %0b exp 1", o_active); end
      checks++; if (o_srcAddr !== {9'd5, 9'd4}) begin errors++; $display("FAIL prio_run_start_src got %0h exp %0h", o_srcAddr, {9'd5, 9'd4}); end
      i_done = 1'b1; i_nextX = 3'd1;
      tick();
      i_done = 1'b0;
      checks++; if (o_active !== 1'b0) begin errors++; $display("FAIL prio_active got %0b exp 0", o_active); end
      checks++; if (o_srcAddr !== {9'd5, 9'd4}) begin errors++; $display("FAIL prio_idx got %0h exp %0h", o_srcAddr, {9'd5, 9'd4}); end
      tick();
      checks++; if (o_srcAddr !== {9'd5, 9'd4}) begin errors++; $display("FAIL prio_idle_step got %0h exp %0h", o_srcAddr, {9'd5, 9'd4}); end
      i_nextX = 3'd0;
   endtask

   task automatic test_illegal_and_reset();
      load_cmd(10'd0, 9'd0, 10'd0, 9'd0, 10'd8, 9'd4);
      i_nextX = 3'd3;
      tick();
      checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL ill_err got %0b exp 1", o_err); end
      checks++; if (o_srcAddr !== 18'd0) begin errors++; $display("FAIL ill_hold got %0h exp 0", o_srcAddr); end
      i_nextX = 3'd1; i_nextY = 3'd5;
      tick();
      checks++; if (o_srcAddr !== {9'd0, 9'd1}) begin errors++; $display("FAIL ill_yhold got %0h exp %0h", o_srcAddr, {9'd0, 9'd1}); end
      checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL ill_sticky got %0b exp 1", o_err); end
      finish_cmd();
      checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL ill_idle_sticky got %0b exp 1", o_err); end
      load_cmd(10'd0, 9'd0, 10'd0, 9'd0, 10'd8, 9'd4);
      checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL ill_start_clear got %0b exp 0", o_err); end
      i_nextX = 3'd7; i_nextY = 3'd4;
      tick();
      i_nextX = 3'd0; i_nextY = 3'd0;
      checks++; if (o_srcAddr !== {9'd1, 9'd0}) begin errors++; $display("FAIL ill_xhold got %0h exp %0h", o_srcAddr, {9'd1, 9'd0}); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++; if (o_active !== 1'b0) begin errors++; $display("FAIL rst_active got %0b exp 0", o_active); end
      checks++; if (o_srcAddr !== 18'd0) begin errors++; $display("FAIL rst_src got %0h exp 0", o_srcAddr); end
      checks++; if (o_dstAddr !== 18'd0) begin errors++; $display("FAIL rst_dst got %0h exp 0", o_dstAddr); end
      checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL rst_err got %0b exp 0", o_err); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_odd_start();
      test_wrap();
      test_full_size();
      test_done_priority();
      test_illegal_and_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
